// File: rtl/memlcd_pkg.sv
// Shared constants, command encodings and FSM state type for the memory-LCD
// update controller.
package memlcd_pkg;

  localparam int unsigned LINES       = 536;
  localparam int unsigned LINE_W      = 10;
  localparam int unsigned VCOM_CYCLES = 12_000_000;

  typedef enum logic [1:0] {
    OP_WRITE_LINE = 2'd0,
    OP_CLEAR_ALL  = 2'd1,
    OP_VCOM_ONLY  = 2'd2
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/memlcd_update_ctrl_if.sv
// Command channel between the update controller (master) and the SPI line
// engine (slave).
interface memlcd_update_ctrl_if #(
  parameter int unsigned LINE_W = memlcd_pkg::LINE_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LINE_W-1:0] cmd_line;
  logic              cmd_vcom;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_line, cmd_vcom,
    input  cmd_ready, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_line, cmd_vcom,
    output cmd_ready, done
  );

endinterface

// File: rtl/memlcd_vcom_timer.sv
// Free-running VCOM divider: toggles the VCOM level every VCOM_CYCLES clocks
// and flags the terminal count for one cycle.
module memlcd_vcom_timer #(
  parameter int unsigned VCOM_CYCLES = memlcd_pkg::VCOM_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_vcom,
  output logic o_tc
);

  localparam int unsigned CW = (VCOM_CYCLES > 1) ? $clog2(VCOM_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_vcom;
  logic          w_tc;

  assign w_tc   = (r_cnt == CW'(VCOM_CYCLES - 1));
  assign o_tc   = w_tc;
  assign o_vcom = r_vcom;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_vcom <= 1'b0;
    end else if (w_tc) begin
      r_cnt  <= '0;
      r_vcom <= ~r_vcom;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/memlcd_update_ctrl.sv
// Memory-LCD refresh scheduler: tracks dirty lines, arbitrates clear / VCOM /
// line writes and hands one command at a time to the SPI line engine.
module memlcd_update_ctrl
  import memlcd_pkg::*;
#(
  parameter int unsigned LINES       = memlcd_pkg::LINES,
  parameter int unsigned VCOM_CYCLES = memlcd_pkg::VCOM_CYCLES,
  parameter int unsigned LINE_W      = memlcd_pkg::LINE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 dirty_valid,
  input  logic [LINE_W-1:0]    dirty_line,
  input  logic                 update_all,
  input  logic                 clear_req,
  memlcd_update_ctrl_if.master cmd,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_badline
);

  localparam logic [LINE_W-1:0] LAST = LINE_W'(LINES);

  state_t            r_state, w_state_nxt;
  logic [LINES:1]    r_map, w_map_nxt;
  logic [LINE_W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
  logic              r_clear_pend, r_vcom_pend;
  logic              r_cmd_valid;
  cmd_op_t           r_cmd_op, w_op_nxt;
  logic [LINE_W-1:0] r_cmd_line, w_line_nxt;
  logic              r_frame_done, r_err;
  logic              w_vcom, w_tc;
  logic              w_hs, w_dirty_ok, w_map_empty;

  memlcd_vcom_timer #(.VCOM_CYCLES(VCOM_CYCLES)) u_vcom (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_vcom (w_vcom),
    .o_tc   (w_tc)
  );

  assign w_hs        = r_cmd_valid & cmd.cmd_ready;
  assign w_dirty_ok  = dirty_valid && (dirty_line != '0) && (dirty_line <= LAST);
  assign w_map_empty = (r_map == '0);
  assign w_ptr_inc   = (r_ptr == LAST) ? LINE_W'(1) : r_ptr + 1'b1;

  assign cmd.cmd_valid = r_cmd_valid;
  assign cmd.cmd_op    = r_cmd_op;
  assign cmd.cmd_line  = r_cmd_line;
  assign cmd.cmd_vcom  = w_vcom;
  assign busy          = (r_state != ST_IDLE);
  assign frame_done    = r_frame_done;
  assign err_badline   = r_err;

  // Clears are applied before sets so a re-mark in the handshake cycle survives.
  always_comb begin
    w_map_nxt = r_map;
    if (w_hs && r_cmd_op == OP_CLEAR_ALL) w_map_nxt = '0;
    if (w_hs && r_cmd_op == OP_WRITE_LINE) w_map_nxt[r_cmd_line] = 1'b0;
    if (update_all) w_map_nxt = '1;
    if (w_dirty_ok) w_map_nxt[dirty_line] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_cmd_op;
    w_line_nxt  = r_cmd_line;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      ST_IDLE: begin
        if (en) begin
          if (r_clear_pend) begin
            w_state_nxt = ST_ISSUE;
            w_op_nxt    = OP_CLEAR_ALL;
            w_line_nxt  = '0;
          end else if (r_vcom_pend && w_map_empty) begin
            w_state_nxt = ST_ISSUE;
            w_op_nxt    = OP_VCOM_ONLY;
            w_line_nxt  = '0;
          end else if (!w_map_empty) begin
            w_state_nxt = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_clear_pend) begin
          w_state_nxt = ST_ISSUE;
          w_op_nxt    = OP_CLEAR_ALL;
          w_line_nxt  = '0;
        end else if (w_map_empty) begin
          w_state_nxt = ST_IDLE;
        end else begin
          // Pointer always moves past the examined line, giving round-robin fairness.
          w_ptr_nxt = w_ptr_inc;
          if (r_map[r_ptr]) begin
            w_state_nxt = ST_ISSUE;
            w_op_nxt    = OP_WRITE_LINE;
            w_line_nxt  = r_ptr;
          end
        end
      end
      ST_ISSUE: if (w_hs) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (cmd.done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_map        <= '0;
      r_ptr        <= LINE_W'(1);
      r_clear_pend <= 1'b0;
      r_vcom_pend  <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_op     <= OP_WRITE_LINE;
      r_cmd_line   <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_map       <= w_map_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cmd_valid <= (w_state_nxt == ST_ISSUE);
      r_cmd_op    <= w_op_nxt;
      r_cmd_line  <= w_line_nxt;
      if (w_hs && r_cmd_op == OP_CLEAR_ALL) r_clear_pend <= 1'b0;
      if (clear_req) r_clear_pend <= 1'b1;
      if (w_hs) r_vcom_pend <= 1'b0;
      if (w_tc) r_vcom_pend <= 1'b1;
      r_frame_done <= (r_state == ST_WAIT) && cmd.done &&
                      (r_cmd_op == OP_WRITE_LINE) && w_map_empty;
      r_err        <= dirty_valid && !w_dirty_ok;
    end
  end

endmodule

// File: tb/tb_memlcd_update_ctrl.sv
// Directed self-checking bench for memlcd_update_ctrl (VCOM period shortened to 100).
module tb_memlcd_update_ctrl;
  import memlcd_pkg::*;

  localparam int unsigned VC = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        dirty_valid = 1'b0;
  logic [9:0]  dirty_line = '0;
  logic        update_all = 1'b0;
  logic        clear_req = 1'b0;
  logic        busy, frame_done, err_badline;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  memlcd_update_ctrl_if #(.LINE_W(10)) cmd_if ();

  memlcd_update_ctrl #(
    .LINES       (536),
    .VCOM_CYCLES (VC),
    .LINE_W      (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .dirty_valid (dirty_valid),
    .dirty_line  (dirty_line),
    .update_all  (update_all),
    .clear_req   (clear_req),
    .cmd         (cmd_if.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_badline (err_badline)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; dirty_valid = 1'b0; dirty_line = '0;
    update_all = 1'b0; clear_req = 1'b0;
    cmd_if.cmd_ready = 1'b1; cmd_if.done = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int w;
    w = 0;
    while (!cmd_if.cmd_valid && w < limit) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, 32'(cmd_if.cmd_valid), 1);
  endtask

  task automatic finish_cmd(input string tag, input logic exp_frame);
    @(negedge clk);
    chk({tag, "_drop"}, 32'(cmd_if.cmd_valid), 0);
    cmd_if.done = 1'b1;
    @(negedge clk);
    cmd_if.done = 1'b0;
    chk({tag, "_frame"}, 32'(frame_done), 32'(exp_frame));
  endtask

  task automatic serve(input string tag, input int exp_op, input int exp_line, input logic exp_frame);
    wait_valid(tag, 2000);
    chk({tag, "_op"}, 32'(cmd_if.cmd_op), exp_op);
    chk({tag, "_line"}, 32'(cmd_if.cmd_line), exp_line);
    finish_cmd(tag, exp_frame);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || cmd_if.cmd_valid || frame_done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int c_prev;
    cmd_if.cmd_ready = 1'b1;
    cmd_if.done      = 1'b0;

    // Reset state
    step(1);
    chk("rst_outs", {busy, cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_line,
                     cmd_if.cmd_vcom, frame_done, err_badline}, 0);

    // Round-robin order 3, 5, 536 from pointer 1; frame_done only after the last
    do_reset();
    en = 1'b1;
    dirty_valid = 1'b1; dirty_line = 10'd5;   step(1);
    dirty_line = 10'd3;                        step(1);
    dirty_line = 10'd536;                      step(1);
    dirty_valid = 1'b0;
    serve("s1_a", 0, 3, 1'b0);
    serve("s1_b", 0, 5, 1'b0);
    serve("s1_c", 0, 536, 1'b1);
    step(1);
    chk("s1_frame_pulse", 32'(frame_done), 0);

    // Clear request with lines 10 and 20 dirty: CLEAR_ALL first, held through en low
    do_reset();
    dirty_valid = 1'b1; dirty_line = 10'd10;  step(1);
    dirty_line = 10'd20;                       step(1);
    dirty_valid = 1'b0; clear_req = 1'b1; cmd_if.cmd_ready = 1'b0; step(1);
    clear_req = 1'b0; en = 1'b1;
    wait_valid("s2", 5);
    chk("s2_op", 32'(cmd_if.cmd_op), 1);
    chk("s2_line", 32'(cmd_if.cmd_line), 0);
    en = 1'b0;
    step(3);
    chk("s2_hold_valid", 32'(cmd_if.cmd_valid), 1);
    chk("s2_hold_op", 32'(cmd_if.cmd_op), 1);
    cmd_if.cmd_ready = 1'b1;
    finish_cmd("s2", 1'b0);
    en = 1'b1;
    quiet("s2_no_write", 30);

    // clear_req to cmd_valid latency
    do_reset();
    en = 1'b1;
    clear_req = 1'b1; step(1);
    clear_req = 1'b0;
    chk("lat_c1", 32'(cmd_if.cmd_valid), 0);
    step(1);
    chk("lat_c2", 32'(cmd_if.cmd_valid), 1);
    chk("lat_op", 32'(cmd_if.cmd_op), 1);
    finish_cmd("lat", 1'b0);

    // Idle VCOM_ONLY every VC cycles with alternating VCOM bit
    do_reset();
    en = 1'b1;
    c_prev = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_valid("s3", 150);
      chk("s3_op", 32'(cmd_if.cmd_op), 2);
      chk("s3_line", 32'(cmd_if.cmd_line), 0);
      chk("s3_vcom", 32'(cmd_if.cmd_vcom), (k == 1) ? 0 : 1);
      chk("s3_period", cyc - c_prev, (k == 0) ? VC + 1 : VC);
      c_prev = cyc;
      finish_cmd("s3", 1'b0);
    end

    // Re-mark line 7 in its handshake cycle: written twice
    do_reset();
    en = 1'b1; cmd_if.cmd_ready = 1'b0;
    dirty_valid = 1'b1; dirty_line = 10'd7; step(1);
    dirty_valid = 1'b0;
    wait_valid("s4_a", 50);
    chk("s4_a_line", 32'(cmd_if.cmd_line), 7);
    cmd_if.cmd_ready = 1'b1; dirty_valid = 1'b1; dirty_line = 10'd7;
    @(negedge clk);
    dirty_valid = 1'b0;
    chk("s4_a_drop", 32'(cmd_if.cmd_valid), 0);
    cmd_if.done = 1'b1; step(1); cmd_if.done = 1'b0;
    chk("s4_a_frame", 32'(frame_done), 0);
    serve("s4_b", 0, 7, 1'b1);

    // Bad line numbers: error pulse, map untouched
    do_reset();
    chk("s5_err0", 32'(err_badline), 0);
    dirty_valid = 1'b1; dirty_line = 10'd0; step(1);
    chk("s5_err_line0", 32'(err_badline), 1);
    dirty_line = 10'd537; step(1);
    chk("s5_err_line537", 32'(err_badline), 1);
    dirty_valid = 1'b0; step(1);
    chk("s5_err_clear", 32'(err_badline), 0);
    en = 1'b1;
    quiet("s5_map_empty", 30);

    // Reset while waiting for done discards the command
    do_reset();
    en = 1'b1;
    dirty_valid = 1'b1; dirty_line = 10'd12; step(1);
    dirty_valid = 1'b0;
    wait_valid("s6", 50);
    chk("s6_line", 32'(cmd_if.cmd_line), 12);
    step(1);
    chk("s6_wait_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_outs", {busy, cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_line,
                        cmd_if.cmd_vcom, frame_done, err_badline}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_if.done = 1'b1; step(1); cmd_if.done = 1'b0;
    quiet("s6_no_reissue", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memlcd_update_ctrl.md
MEMLCD_UPDATE_CTRL -- requirements
Module: memlcd_update_ctrl

Interface
REQ-001 Parameters: LINES = 536, number of panel lines; VCOM_CYCLES = 12_000_000, clk cycles per VCOM half-period; LINE_W = 10, line-number width.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  scheduling enable; low = no new commands, in-flight command completes.
REQ-005 dirty_valid  in  1  one-cycle strobe marking dirty_line dirty.
REQ-006 dirty_line  in  LINE_W  1-based line number, 1..LINES.
REQ-007 update_all  in  1  strobe marking every line dirty.
REQ-008 clear_req  in  1  strobe requesting panel all-clear.
REQ-009 cmd_valid  out  1  command to SPI line engine valid.
REQ-010 cmd_ready  in  1  engine accepts command.
REQ-011 cmd_op  out  2  0 = WRITE_LINE, 1 = CLEAR_ALL, 2 = VCOM_ONLY.
REQ-012 cmd_line  out  LINE_W  line for WRITE_LINE, 0 otherwise.
REQ-013 cmd_vcom  out  1  VCOM bit embedded in the command.
REQ-014 done  in  1  engine one-cycle pulse: transaction finished (scs deasserted).
REQ-015 busy  out  1  high while state is not IDLE.
REQ-016 frame_done  out  1  one-cycle pulse when the dirty map becomes empty after at least one WRITE_LINE.
REQ-017 err_badline  out  1  one-cycle pulse when dirty_valid carries line 0 or a line > LINES.

Function
REQ-018 States: IDLE, SCAN, ISSUE, WAIT.
- IDLE→ISSUE: en=1 and clear/vcom pending.
- IDLE→SCAN: en=1 and map non-empty.
- SCAN→ISSUE: dirty line found.
- ISSUE→WAIT: cmd_valid&cmd_ready.
- WAIT→IDLE: done.
REQ-019 Dirty map: LINES bits. Set by dirty_valid (valid line only) or update_all. Bit cleared in the cycle its WRITE_LINE handshakes.
REQ-020 Set and clear of the same bit in the same cycle: set wins. The line is rewritten later.
REQ-021 A bad dirty_line shall leave the map unchanged and pulse err_badline the next cycle.
REQ-022 SCAN examines one bit per cycle from a round-robin pointer (reset value 1), wrapping LINES→1.
- Found line is loaded into cmd_line; pointer advances to line+1.
- Fairness: no line is starved by repeated marking of lower lines.
REQ-023 Priority at IDLE/ISSUE entry: pending clear > pending VCOM > dirty lines.
REQ-024 A clear_req pulse sets clear_pending (sticky until issued).
- Issuing CLEAR_ALL also zeroes the dirty map.
- update_all arriving in the same cycle as that issue is retained (set wins).
REQ-025 VCOM timer:
- Counts 0..VCOM_CYCLES-1 continuously, independent of en.
- At terminal count: toggles the vcom register and sets vcom_pending.
- cmd_vcom always equals the vcom register.
REQ-026 vcom_pending clears on the handshake of any command. VCOM_ONLY is issued only when vcom_pending is set and the map is empty.
REQ-027 Handshake:
- cmd_valid rises the cycle after ISSUE entry.
- Payload stays stable until cmd_ready.
- cmd_valid drops the cycle after the handshake.
- Once asserted, cmd_valid is never withdrawn, including if en falls.
REQ-028 done outside WAIT shall be ignored. Exactly one command is outstanding at a time.
REQ-029 Latency: clear_req in IDLE (en=1, cmd_ready=1) shall give cmd_valid 2 cycles later (latch, ISSUE).
REQ-030 en low in SCAN returns to IDLE without issuing. The pointer is kept.

Reset
REQ-031 On rst_n low, asynchronously:
- all outputs 0;
- state IDLE;
- dirty map cleared;
- clear_pending and vcom_pending 0;
- vcom 0, timer 0, pointer 1.
REQ-032 Reset mid-transaction discards the outstanding command. A subsequent done pulse is ignored.

Structure
REQ-033 Package memlcd_pkg shall hold the cmd_op encodings, LINES, LINE_W and the state enum.
REQ-034 VCOM divider shall be sub-module memlcd_vcom_timer, which outputs the vcom level and a terminal-count pulse.

Verification
REQ-035 Directed scenarios:
- Mark lines 5, 3, 536 (pointer 1): WRITE_LINE 3, 5, 536 in order; one frame_done after the third done.
- clear_req with lines 10 and 20 dirty: CLEAR_ALL first; map empty after; no WRITE_LINE follows.
- VCOM_CYCLES=100, idle: VCOM_ONLY every 100 cycles; cmd_vcom alternates 1,0,1.
- Re-mark line 7 in the cycle its WRITE_LINE handshakes: line 7 written twice.
- dirty_line=0 and 537: err_badline pulse each; map unchanged.
- rst_n low in WAIT after issuing line 12, then done pulse: no response; line 12 not rewritten; all outputs 0.
